memory_stage: RTL and testbench
===============================

# memory_stage

Memory stage of the Y86-64 five-stage pipeline. It consumes the M pipeline register fields, performs the data-memory access for loads, stores and stack operations, and produces the stage status. It exposes the combinational `m_valM`/`m_stat` for forwarding and hazard logic, and it owns the W pipeline register that feeds write-back (`W_icode`, `W_valE`, `W_valM`, `W_dstE`, `W_dstM`, `W_stat`).

## Interface
- `MEM_BYTES`, 1024: data-memory size in bytes, byte-addressed, little-endian.
- `clk` input 1: single clock; all state changes on rising edge.
- `rst_n` input 1: reset is synchronous and active-low.
- `M_icode` input 4: instruction code in M.
- `M_stat` input 4: status carried into M (1 AOK, 2 HLT, 3 ADR, 4 INS).
- `M_valE` input 64: ALU result; also the address for rmmovq, mrmovq, pushq and call.
- `M_valA` input 64: store data; also the address for popq and ret.
- `M_dstE` input 4: destination register for valE; 4'hF means none.
- `M_dstM` input 4: destination register for valM; 4'hF means none.
- `W_stall` input 1: hold the W register.
- `W_bubble` input 1: load a bubble into W.
- `m_valM` output 64: combinational memory read data; 0 when no read occurs.
- `m_stat` output 4: combinational stage status.
- `dmem_error` output 1: combinational address fault for the current access.
- `W_icode`, `W_stat`, `W_dstE`, `W_dstM` output 4: registered W fields.
- `W_valE`, `W_valM` output 64: registered W fields.

## Operation
- Read class: mrmovq (5), popq (B), ret (9).
- Write class: rmmovq (4), pushq (A), call (8).
- Address: `M_valA` for popq and ret. `M_valE` for the other read/write instructions.
- Read data: 8 bytes at addr..addr+7, assembled little-endian (byte at addr is bits 7:0).
- Write data: `M_valA`, written as 8 bytes little-endian.
- `dmem_error` is 1 when the instruction is read or write class and addr > MEM_BYTES-8. Compare as unsigned 64-bit, so wrap-around addresses such as 64'hFFFF_FFFF_FFFF_FFFC fault.
- `m_stat` = 3 (ADR) if `dmem_error`, else `M_stat`.
- A faulting read returns `m_valM` = 0.
- A memory write commits at the rising edge only when all of these hold: write class, `rst_n`=1, `dmem_error`=0, `M_stat`=1 (AOK).
  - Memory is never written for an instruction that already carries an exception or that faults.
- W register update priority, highest first:
  1. `!rst_n`: load a bubble.
  2. `W_stall`: hold all W fields.
  3. `W_bubble`: load a bubble.
  4. Otherwise load `M_icode`, `m_stat`, `M_valE`, `m_valM`, `M_dstE`, `M_dstM`.
- Bubble values: `W_icode`=1 (nop), `W_stat`=1, `W_valE`=0, `W_valM`=0, `W_dstE`=F, `W_dstM`=F.
- `W_stall` and `W_bubble` asserted together: stall wins.
- Memory contents are zero at time 0 and are not cleared by reset.

## Timing
- Reset value of every registered output is the bubble value. `m_valM`, `m_stat` and `dmem_error` follow their inputs in the same cycle, including during reset.
- Read latency: 0 cycles to `m_valM`. The W register presents the value 1 cycle later.
- A write at edge N is visible to a read in cycle N+1. A read in the same cycle as the write sees the old data.
- A write is not gated by `W_stall`. A repeated identical store from a held M stage is idempotent.
- If reset asserts in a cycle, that cycle's write is suppressed and W becomes a bubble at the same edge.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined: `dmem_error` also asserts when addr[2:0] != 0 for read or write class. This yields ADR, no write, and `m_valM`=0.
- `MEM_ALIGN_CHECK_EN` not defined: unaligned 8-byte accesses are legal and byte-exact.

## Test plan
- Reset, then release with M idle (icode 1): W reads 1/1/0/0/F/F; `m_valM`=0.
- rmmovq with valE=0x10, valA=0x1122334455667788, then next cycle mrmovq with valE=0x10, dstM=3: `m_valM`=0x1122334455667788. Following cycle W_valM = that value and W_dstM=3.
- pushq with valE=0x3F8, valA=0xAB, then popq with valA=0x3F8, valE=0x400: `m_valM`=0xAB, W_valE=0x400.
- rmmovq with valE=MEM_BYTES-4: `dmem_error`=1, `m_stat`=3, no write; a subsequent read of MEM_BYTES-8 returns the old data. Repeat with M_stat=4 at a legal address: no write, `m_stat`=4.
- Hold W_stall=1 for 2 cycles while M changes: W fields unchanged. Then W_bubble=1: W loads the bubble. Both W_stall and W_bubble=1: W holds.
- With `MEM_ALIGN_CHECK_EN` defined, mrmovq at 0x13: ADR, `m_valM`=0. Without it: returns bytes 0x13..0x1A.

Source files
------------

// File: rtl/memory_stage.sv
// Y86-64 memory stage: byte-addressed little-endian data memory plus the W pipeline register.
// Optional build macro MEM_ALIGN_CHECK_EN makes unaligned 8-byte accesses fault.
module memory_stage #(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  M_icode,
  input  logic [3:0]  M_stat,
  input  logic [63:0] M_valE,
  input  logic [63:0] M_valA,
  input  logic [3:0]  M_dstE,
  input  logic [3:0]  M_dstM,
  input  logic        W_stall,
  input  logic        W_bubble,
  output logic [63:0] m_valM,
  output logic [3:0]  m_stat,
  output logic        dmem_error,
  output logic [3:0]  W_icode,
  output logic [3:0]  W_stat,
  output logic [63:0] W_valE,
  output logic [63:0] W_valM,
  output logic [3:0]  W_dstE,
  output logic [3:0]  W_dstM
);
  localparam int AW = $clog2(MEM_BYTES);

  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] S_AOK    = 4'h1;
  localparam logic [3:0] S_ADR    = 4'h3;
  localparam logic [63:0] ADDR_MAX = 64'(MEM_BYTES - 8);

  // Zero-initialised storage; reset deliberately leaves contents untouched.
  logic [7:0] mem [MEM_BYTES] = '{default: 8'h00};

  logic        is_read;
  logic        is_write;
  logic [63:0] addr;
  logic [AW-1:0] idx;
  logic [63:0] rd_data;
  logic        mem_we;

  assign is_read  = (M_icode == I_MRMOVQ) || (M_icode == I_POPQ) || (M_icode == I_RET);
  assign is_write = (M_icode == I_RMMOVQ) || (M_icode == I_PUSHQ) || (M_icode == I_CALL);
  assign addr     = ((M_icode == I_POPQ) || (M_icode == I_RET)) ? M_valA : M_valE;
  assign idx      = addr[AW-1:0];

`ifdef MEM_ALIGN_CHECK_EN
  assign dmem_error = (is_read || is_write) && ((addr > ADDR_MAX) || (addr[2:0] != 3'b000));
`else
  assign dmem_error = (is_read || is_write) && (addr > ADDR_MAX);
`endif

  // Byte lanes are only meaningful when the access is in range; the mux below masks the rest.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_rd
      assign rd_data[8*gi +: 8] = mem[idx + AW'(gi)];
    end
  endgenerate

  assign m_valM = (is_read && !dmem_error) ? rd_data : 64'h0;
  assign m_stat = dmem_error ? S_ADR : M_stat;
  assign mem_we = is_write && rst_n && !dmem_error && (M_stat == S_AOK);

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 8; i++) begin
        mem[idx + AW'(i)] <= M_valA[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || (!W_stall && W_bubble)) begin
      W_icode <= I_NOP;
      W_stat  <= S_AOK;
      W_valE  <= 64'h0;
      W_valM  <= 64'h0;
      W_dstE  <= 4'hF;
      W_dstM  <= 4'hF;
    end else if (!W_stall) begin
      W_icode <= M_icode;
      W_stat  <= m_stat;
      W_valE  <= M_valE;
      W_valM  <= m_valM;
      W_dstE  <= M_dstE;
      W_dstM  <= M_dstM;
    end
  end
endmodule

// File: tb/tb_memory_stage.sv
// Directed table-driven bench for memory_stage: combinational outputs checked before each edge, W after it.
module tb_memory_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  M_icode, M_stat, M_dstE, M_dstM;
  logic [63:0] M_valE, M_valA;
  logic        W_stall, W_bubble;
  logic [63:0] m_valM, W_valE, W_valM;
  logic [3:0]  m_stat, W_icode, W_stat, W_dstE, W_dstM;
  logic        dmem_error;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  memory_stage #(.MEM_BYTES(1024)) dut (
    .clk(clk), .rst_n(rst_n),
    .M_icode(M_icode), .M_stat(M_stat), .M_valE(M_valE), .M_valA(M_valA),
    .M_dstE(M_dstE), .M_dstM(M_dstM), .W_stall(W_stall), .W_bubble(W_bubble),
    .m_valM(m_valM), .m_stat(m_stat), .dmem_error(dmem_error),
    .W_icode(W_icode), .W_stat(W_stat), .W_valE(W_valE), .W_valM(W_valM),
    .W_dstE(W_dstE), .W_dstM(W_dstM)
  );

  typedef struct {
    logic        rst_n;
    logic [3:0]  icode;
    logic [3:0]  stat;
    logic [63:0] valE;
    logic [63:0] valA;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
    logic        stall;
    logic        bubble;
    logic [63:0] e_valM;
    logic [3:0]  e_mstat;
    logic        e_err;
    logic [3:0]  e_wicode;
    logic [3:0]  e_wstat;
    logic [63:0] e_wvalE;
    logic [63:0] e_wvalM;
    logic [3:0]  e_wdstE;
    logic [3:0]  e_wdstM;
  } vec_t;

  vec_t vecs[$];

  // Unaligned read at 0x13 after the store at 0x10 and the call at 0x18.
`ifdef MEM_ALIGN_CHECK_EN
  localparam logic [63:0] U_VALM = 64'h0;
  localparam logic [3:0]  U_STAT = 4'h3;
  localparam logic        U_ERR  = 1'b1;
`else
  localparam logic [63:0] U_VALM = 64'h0607_0811_2233_4455;
  localparam logic [3:0]  U_STAT = 4'h1;
  localparam logic        U_ERR  = 1'b0;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    M_icode = 4'h1; M_stat = 4'h1; M_valE = 64'h0; M_valA = 64'h0;
    M_dstE = 4'hF; M_dstM = 4'hF; W_stall = 1'b0; W_bubble = 1'b0;
  endtask

  task automatic chk_w_bubble(input string tag);
    chk({tag, "_W_icode"}, 64'(W_icode), 64'h1);
    chk({tag, "_W_stat"},  64'(W_stat),  64'h1);
    chk({tag, "_W_valE"},  W_valE,       64'h0);
    chk({tag, "_W_valM"},  W_valM,       64'h0);
    chk({tag, "_W_dstE"},  64'(W_dstE),  64'hF);
    chk({tag, "_W_dstM"},  64'(W_dstM),  64'hF);
  endtask

  initial begin
    // rst icode stat valE valA dstE dstM stall bubble | m_valM m_stat err | W icode stat valE valM dstE dstM
    vecs.push_back('{1'b0, 4'h4, 4'h1, 64'h100, 64'hDEAD, 4'hF, 4'hF, 1'b0, 1'b0, 64'h0, 4'h1, 1'b0, 4'h1, 4'h1, 64'h0, 64'h0, 4'hF, 4'hF});
    vecs.push_back('{1'b1, 4'h1, 4'h1, 64'h0, 64'h0, 4'hF, 4'hF, 1'b0, 1'b0, 64'h0, 4'h1, 1'b0, 4'h1, 4'h1, 64'h0, 64'h0, 4'hF, 4'hF});
    vecs.push_back('{1'b1, 4'h5, 4'h1, 64'h100, 64'h0, 4'hF, 4'h2, 1'b0, 1'b0, 64'h0, 4'h1, 1'b0, 4'h5, 4'h1, 64'h100, 64'h0, 4'hF, 4'h2});
    vecs.push_back('{1'b1, 4'h4, 4'h1, 64'h10, 64'h1122334455667788, 4'hF, 4'hF, 1'b0, 1'b0, 64'h0, 4'h1, 1'b0, 4'h4, 4'h1, 64'h10, 64'h0, 4'hF, 4'hF});
    vecs.push_back('{1'b1, 4'h5, 4'h1, 64'h10, 64'h0, 4'hF, 4'h3, 1'b0, 1'b0, 64'h1122334455667788, 4'h1, 1'b0, 4'h5, 4'h1, 64'h10, 64'h1122334455667788, 4'hF, 4'h3});
    vecs.push_back('{1'b1, 4'hA, 4'h1, 64'h3F8, 64'hAB, 4'h4, 4'hF, 1'b0, 1'b0, 64'h0, 4'h1, 1'b0, 4'hA, 4'h1, 64'h3F8, 64'h0, 4'h4, 4'hF});
    vecs.push_back('{1'b1, 4'hB, 4'h1, 64'h400, 64'h3F8, 4'h4, 4'h5, 1'b0, 1'b0, 64'hAB, 4'h1, 1'b0, 4'hB, 4'h1, 64'h400, 64'hAB, 4'h4, 4'h5});
    vecs.push_back('{1'b1, 4'h4, 4'h1, 64'h3FC, 64'hFFFF_FFFF_FFFF_FFFF, 4'hF, 4'hF, 1'b0, 1'b0, 64'h0, 4'h3, 1'b1, 4'h4, 4'h3, 64'h3FC, 64'h0, 4'hF, 4'hF});
    vecs.push_back('{1'b1, 4'h5, 4'h1, 64'h3F8, 64'h0, 4'hF, 4'h1, 1'b0, 1'b0, 64'hAB, 4'h1, 1'b0, 4'h5, 4'h1, 64'h3F8, 64'hAB, 4'hF, 4'h1});
    vecs.push_back('{1'b1, 4'h4, 4'h4, 64'h3F8, 64'h55, 4'hF, 4'hF, 1'b0, 1'b0, 64'h0, 4'h4, 1'b0, 4'h4, 4'h4, 64'h3F8, 64'h0, 4'hF, 4'hF});
    vecs.push_back('{1'b1, 4'h5, 4'h1, 64'h3F8, 64'h0, 4'hF, 4'h1, 1'b0, 1'b0, 64'hAB, 4'h1, 1'b0, 4'h5, 4'h1, 64'h3F8, 64'hAB, 4'hF, 4'h1});
    vecs.push_back('{1'b1, 4'h5, 4'h1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 4'hF, 4'h1, 1'b0, 1'b0, 64'h0, 4'h3, 1'b1, 4'h5, 4'h3, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 4'hF, 4'h1});
    vecs.push_back('{1'b1, 4'h9, 4'h1, 64'h408, 64'h3F8, 4'hF, 4'hF, 1'b0, 1'b0, 64'hAB, 4'h1, 1'b0, 4'h9, 4'h1, 64'h408, 64'hAB, 4'hF, 4'hF});
    vecs.push_back('{1'b1, 4'h5, 4'h1, 64'h3F9, 64'h0, 4'hF, 4'h1, 1'b0, 1'b0, 64'h0, 4'h3, 1'b1, 4'h5, 4'h3, 64'h3F9, 64'h0, 4'hF, 4'h1});
    vecs.push_back('{1'b1, 4'h8, 4'h1, 64'h18, 64'h0102030405060708, 4'h4, 4'hF, 1'b0, 1'b0, 64'h0, 4'h1, 1'b0, 4'h8, 4'h1, 64'h18, 64'h0, 4'h4, 4'hF});
    vecs.push_back('{1'b1, 4'h5, 4'h1, 64'h13, 64'h0, 4'hF, 4'h6, 1'b0, 1'b0, U_VALM, U_STAT, U_ERR, 4'h5, U_STAT, 64'h13, U_VALM, 4'hF, 4'h6});
    // Stall holds W across changing M, stall beats bubble, then bubble alone.
    vecs.push_back('{1'b1, 4'h1, 4'h1, 64'h999, 64'h0, 4'hF, 4'hF, 1'b1, 1'b0, 64'h0, 4'h1, 1'b0, 4'h5, U_STAT, 64'h13, U_VALM, 4'hF, 4'h6});
    vecs.push_back('{1'b1, 4'h5, 4'h1, 64'h10, 64'h0, 4'h2, 4'h3, 1'b1, 1'b0, 64'h1122334455667788, 4'h1, 1'b0, 4'h5, U_STAT, 64'h13, U_VALM, 4'hF, 4'h6});
    vecs.push_back('{1'b1, 4'h5, 4'h1, 64'h10, 64'h0, 4'h2, 4'h3, 1'b1, 1'b1, 64'h1122334455667788, 4'h1, 1'b0, 4'h5, U_STAT, 64'h13, U_VALM, 4'hF, 4'h6});
    vecs.push_back('{1'b1, 4'h5, 4'h1, 64'h10, 64'h0, 4'h2, 4'h3, 1'b0, 1'b1, 64'h1122334455667788, 4'h1, 1'b0, 4'h1, 4'h1, 64'h0, 64'h0, 4'hF, 4'hF});
    // A store still commits while W is stalled.
    vecs.push_back('{1'b1, 4'h4, 4'h1, 64'h30, 64'h99, 4'hF, 4'hF, 1'b1, 1'b0, 64'h0, 4'h1, 1'b0, 4'h1, 4'h1, 64'h0, 64'h0, 4'hF, 4'hF});
    vecs.push_back('{1'b1, 4'h5, 4'h1, 64'h30, 64'h0, 4'hF, 4'h2, 1'b0, 1'b0, 64'h99, 4'h1, 1'b0, 4'h5, 4'h1, 64'h30, 64'h99, 4'hF, 4'h2});

    // Reset with M idle.
    rst_n = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    chk_w_bubble("reset");
    chk("reset_m_valM", m_valM, 64'h0);
    chk("reset_m_stat", 64'(m_stat), 64'h1);
    $display("reset: W_icode=%h W_stat=%h W_dstE=%h W_dstM=%h m_valM=%h", W_icode, W_stat, W_dstE, W_dstM, m_valM);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst_n = vecs[i].rst_n; M_icode = vecs[i].icode; M_stat = vecs[i].stat;
      M_valE = vecs[i].valE; M_valA = vecs[i].valA; M_dstE = vecs[i].dstE; M_dstM = vecs[i].dstM;
      W_stall = vecs[i].stall; W_bubble = vecs[i].bubble;
      #1;
      chk($sformatf("v%0d_m_valM", i), m_valM, vecs[i].e_valM);
      chk($sformatf("v%0d_m_stat", i), 64'(m_stat), 64'(vecs[i].e_mstat));
      chk($sformatf("v%0d_dmem_error", i), 64'(dmem_error), 64'(vecs[i].e_err));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_W_icode", i), 64'(W_icode), 64'(vecs[i].e_wicode));
      chk($sformatf("v%0d_W_stat", i), 64'(W_stat), 64'(vecs[i].e_wstat));
      chk($sformatf("v%0d_W_valE", i), W_valE, vecs[i].e_wvalE);
      chk($sformatf("v%0d_W_valM", i), W_valM, vecs[i].e_wvalM);
      chk($sformatf("v%0d_W_dstE", i), 64'(W_dstE), 64'(vecs[i].e_wdstE));
      chk($sformatf("v%0d_W_dstM", i), 64'(W_dstM), 64'(vecs[i].e_wdstM));
      $display("vec %0d: icode=%h valE=%h valA=%h -> m_valM=%h m_stat=%h err=%b W=%h/%h/%h/%h/%h/%h",
               i, vecs[i].icode, vecs[i].valE, vecs[i].valA, m_valM, m_stat, dmem_error,
               W_icode, W_stat, W_valE, W_valM, W_dstE, W_dstM);
    end

    // Reset arriving mid-run: bubble at that edge, store suppressed, earlier memory kept.
    @(negedge clk);
    rst_n = 1'b0; M_icode = 4'h4; M_stat = 4'h1; M_valE = 64'h30; M_valA = 64'h5A;
    M_dstE = 4'hF; M_dstM = 4'hF; W_stall = 1'b1; W_bubble = 1'b0;
    @(posedge clk);
    #1;
    chk_w_bubble("midreset");
    @(negedge clk);
    rst_n = 1'b1; M_icode = 4'h5; M_valE = 64'h30; M_dstM = 4'h2; W_stall = 1'b0;
    #1;
    chk("midreset_read_old", m_valM, 64'h99);
    $display("midreset: W_icode=%h m_valM=%h", W_icode, m_valM);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
